// File: rtl/max_pool_unit.sv
// max_pool_unit: per-channel windowed signed max pooling with ready/valid output
// Ports: clk/reset (async, active-high); in_valid/in_ready/in_data/in_ch sample input;
//   clear flushes partial windows; out_valid/out_ready/out_data/out_ch pooled result;
//   err_ch sticky flag for out-of-range channel index.
// Build option: define MAX_POOL_RELU_EN to clamp negative results to zero on output.
module max_pool_unit #(
  parameter int N = 16,
  parameter int WIN = 4,
  parameter int CH = 4,
  localparam int CW = CH > 1 ? $clog2(CH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic [CW-1:0] in_ch,
  input  logic          clear,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data,
  output logic [CW-1:0] out_ch,
  output logic          err_ch
);
  localparam int CNW = WIN > 1 ? $clog2(WIN) : 1;
  logic [N-1:0]   max_r [CH];
  logic [CNW-1:0] cnt_r [CH];
  logic [N-1:0]   cur_max, new_max, res;
  logic [CNW-1:0] cur_cnt;
  logic           take, ch_ok, acc, last;
  assign in_ready = !out_valid || out_ready;
  assign take     = in_valid && in_ready && !clear;
  assign ch_ok    = int'(in_ch) < CH;
  assign acc      = take && ch_ok;
  always_comb begin
    cur_max = ch_ok ? max_r[in_ch] : '0;
    cur_cnt = ch_ok ? cnt_r[in_ch] : '0;
    last    = cur_cnt == CNW'(WIN - 1);
    // first sample of a window overwrites, so stale maxima never leak across windows
    new_max = (cur_cnt == '0) ? in_data :
              ($signed(in_data) > $signed(cur_max)) ? in_data : cur_max;
`ifdef MAX_POOL_RELU_EN
    res = new_max[N-1] ? '0 : new_max;
`else
    res = new_max;
`endif
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CH; i++) begin
        max_r[i] <= '0;
        cnt_r[i] <= '0;
      end
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      err_ch    <= 1'b0;
    end else begin
      if (clear) begin
        for (int i = 0; i < CH; i++) cnt_r[i] <= '0;
      end else if (acc) begin
        max_r[in_ch] <= new_max;
        cnt_r[in_ch] <= last ? '0 : cur_cnt + CNW'(1);
      end
      if (take && !ch_ok) err_ch <= 1'b1;
      if (acc && last) begin
        out_valid <= 1'b1;
        out_data  <= res;
        out_ch    <= in_ch;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_max_pool_unit.sv
// tb_max_pool_unit: directed self-checking bench for max_pool_unit
module tb_max_pool_unit;
  logic        clk = 0, reset = 0;
  logic        in_valid = 0, clear = 0, out_ready = 1;
  logic [15:0] in_data = 0;
  logic [1:0]  in_ch = 0;
  logic        in_ready, out_valid, err_ch;
  logic [15:0] out_data;
  logic [1:0]  out_ch;
  logic        e_valid = 0, e_ready, e_out_valid, e_err;
  logic [1:0]  e_ch = 0, e_out_ch;
  logic [15:0] e_out_data;
  int checks = 0, errors = 0;
  localparam logic [15:0] NEG_EXP =
`ifdef MAX_POOL_RELU_EN
    16'h0000;
`else
    16'hFF00;
`endif

  max_pool_unit #(.N(16), .WIN(4), .CH(4)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_ch(in_ch), .clear(clear), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch), .err_ch(err_ch));

  max_pool_unit #(.N(16), .WIN(4), .CH(3)) u_err (
    .clk(clk), .reset(reset), .in_valid(e_valid), .in_ready(e_ready),
    .in_data(16'h0100), .in_ch(e_ch), .clear(1'b0), .out_valid(e_out_valid),
    .out_ready(1'b1), .out_data(e_out_data), .out_ch(e_out_ch), .err_ch(e_err));

  always #5 clk = ~clk;

  task automatic send(input logic [1:0] ch, input logic [15:0] d);
    in_valid = 1; in_ch = ch; in_data = d;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    in_valid = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1; #2;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== 16'h0) begin errors++; $display("FAIL rst_out_data: got %h want 0000", out_data); end
    checks++; if (out_ch !== 2'd0) begin errors++; $display("FAIL rst_out_ch: got %0d want 0", out_ch); end
    checks++; if (err_ch !== 1'b0) begin errors++; $display("FAIL rst_err_ch: got %b want 0", err_ch); end
    @(negedge clk); reset = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [15:0] v [4] = '{16'h0300, 16'h0700, 16'h0500, 16'h0200};
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      send(2'd0, v[i]);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid%0d: got %b want 0", i, out_valid); end
    end
    send(2'd0, v[3]);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", out_valid); end
    checks++; if (out_data !== 16'h0700) begin errors++; $display("FAIL basic_data: got %h want 0700", out_data); end
    checks++; if (out_ch !== 2'd0) begin errors++; $display("FAIL basic_ch: got %0d want 0", out_ch); end
    idle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_interleave();
    for (int i = 0; i < 3; i++) begin
      send(2'd0, 16'((i + 1) * 256));
      send(2'd1, 16'((8 - i) * 256));
    end
    send(2'd0, 16'h0400);
    checks++; if (out_valid !== 1'b1 || out_data !== 16'h0400 || out_ch !== 2'd0) begin errors++; $display("FAIL il_ch0: got v=%b d=%h ch=%0d want v=1 d=0400 ch=0", out_valid, out_data, out_ch); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL il_ready: got %b want 1", in_ready); end
    send(2'd1, 16'h0500);
    checks++; if (out_valid !== 1'b1 || out_data !== 16'h0800 || out_ch !== 2'd1) begin errors++; $display("FAIL il_ch1: got v=%b d=%h ch=%0d want v=1 d=0800 ch=1", out_valid, out_data, out_ch); end
    idle();
  endtask

  task automatic test_negative();
    send(2'd2, 16'hFE80);
    send(2'd2, 16'hFD00);
    send(2'd2, 16'hFF00);
    send(2'd2, 16'hFC00);
    checks++; if (out_valid !== 1'b1 || out_data !== NEG_EXP || out_ch !== 2'd2) begin errors++; $display("FAIL neg: got v=%b d=%h ch=%0d want v=1 d=%h ch=2", out_valid, out_data, out_ch, NEG_EXP); end
    idle();
  endtask

  task automatic test_backpressure();
    out_ready = 0;
    send(2'd0, 16'h0100);
    send(2'd0, 16'h0200);
    send(2'd0, 16'h0300);
    send(2'd0, 16'h0900);
    for (int i = 0; i < 3; i++) begin
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready%0d: got %b want 0", i, in_ready); end
      checks++; if (out_valid !== 1'b1 || out_data !== 16'h0900 || out_ch !== 2'd0) begin errors++; $display("FAIL bp_hold%0d: got v=%b d=%h ch=%0d want v=1 d=0900 ch=0", i, out_valid, out_data, out_ch); end
      send(2'd1, 16'h7000);
    end
    in_valid = 0; out_ready = 1; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got %b want 1", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_xfer: got %b want 0", out_valid); end
    for (int i = 0; i < 4; i++) send(2'd1, 16'h0100);
    checks++; if (out_valid !== 1'b1 || out_data !== 16'h0100 || out_ch !== 2'd1) begin errors++; $display("FAIL bp_no_leak: got v=%b d=%h ch=%0d want v=1 d=0100 ch=1", out_valid, out_data, out_ch); end
    idle();
  endtask

  task automatic test_clear();
    send(2'd3, 16'h0900);
    send(2'd3, 16'h0100);
    clear = 1;
    send(2'd3, 16'h7F00);
    clear = 0;
    send(2'd3, 16'h0100);
    send(2'd3, 16'h0200);
    send(2'd3, 16'h0300);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clr_early: got %b want 0", out_valid); end
    send(2'd3, 16'h0400);
    checks++; if (out_valid !== 1'b1 || out_data !== 16'h0400 || out_ch !== 2'd3) begin errors++; $display("FAIL clr_result: got v=%b d=%h ch=%0d want v=1 d=0400 ch=3", out_valid, out_data, out_ch); end
    idle();
  endtask

  task automatic test_err();
    e_valid = 1; e_ch = 2'd3;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
    end
    e_valid = 0;
    checks++; if (e_err !== 1'b1) begin errors++; $display("FAIL err_set: got %b want 1", e_err); end
    checks++; if (e_out_valid !== 1'b0) begin errors++; $display("FAIL err_no_out: got %b want 0", e_out_valid); end
    checks++; if (err_ch !== 1'b0) begin errors++; $display("FAIL err_main_clean: got %b want 0", err_ch); end
    @(posedge clk); #1;
    checks++; if (e_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", e_err); end
  endtask

  task automatic test_reset_mid();
    send(2'd0, 16'h7000);
    send(2'd0, 16'h6000);
    out_ready = 0;
    for (int i = 0; i < 4; i++) send(2'd1, 16'((i + 1) * 256));
    in_valid = 0;
    checks++; if (out_valid !== 1'b1 || out_data !== 16'h0400) begin errors++; $display("FAIL rm_pending: got v=%b d=%h want v=1 d=0400", out_valid, out_data); end
    reset = 1; #1;
    checks++; if (out_valid !== 1'b0 || out_data !== 16'h0) begin errors++; $display("FAIL rm_async: got v=%b d=%h want v=0 d=0000", out_valid, out_data); end
    checks++; if (in_ready !== 1'b1 || e_err !== 1'b0) begin errors++; $display("FAIL rm_ready_err: got rdy=%b err=%b want rdy=1 err=0", in_ready, e_err); end
    #2; reset = 0; out_ready = 1;
    @(posedge clk); #1;
    send(2'd0, 16'h0100);
    send(2'd0, 16'h0300);
    send(2'd0, 16'h0200);
    send(2'd0, 16'h0050);
    checks++; if (out_valid !== 1'b1 || out_data !== 16'h0300 || out_ch !== 2'd0) begin errors++; $display("FAIL rm_fresh: got v=%b d=%h ch=%0d want v=1 d=0300 ch=0", out_valid, out_data, out_ch); end
    idle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_interleave();
    test_negative();
    test_backpressure();
    test_clear();
    test_err();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
